// File: rtl/multiword_adder_controller_pkg.sv
// Shared adder-control definitions: controller state encodings and sizing helpers.
package multiword_adder_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index register width; a single-slice configuration still needs one bit.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/multiword_adder_controller_rca.sv
// Group ripple-carry adder: WIDTH-bit sum of a + b + carry_in with carry out.
module group_ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Unpacked so each carry stage is its own net rather than a self-referencing vector.
    logic carry_chain [WIDTH+1];

    assign carry_chain[0] = carry_in;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]            = a[gi] ^ b[gi] ^ carry_chain[gi];
            assign carry_chain[gi+1]  = (a[gi] & b[gi]) | (carry_chain[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry_out = carry_chain[WIDTH];

endmodule

// File: rtl/multiword_adder_controller.sv
// Multi-cycle wide adder: one CHUNK_WIDTH adder slice reused over CHUNK_COUNT cycles.
module multiword_adder_controller
    import multiword_adder_controller_pkg::*;
#(
    parameter int CHUNK_WIDTH = 4,
    parameter int CHUNK_COUNT = 4,
    localparam int TOTAL_WIDTH = CHUNK_WIDTH * CHUNK_COUNT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [TOTAL_WIDTH-1:0] x,
    input  logic [TOTAL_WIDTH-1:0] y,
    input  logic                   carry_in,
    output logic                   busy,
    output logic                   done,
    output logic [TOTAL_WIDTH-1:0] z,
    output logic                   carry_out
);

    localparam int IDX_W = idx_width(CHUNK_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNK_COUNT - 1);

    state_t state_reg, state_next;

    logic [IDX_W-1:0]       idx_reg;
    logic [TOTAL_WIDTH-1:0] x_reg, y_reg;
    logic                   carry_reg;
    logic                   carry_out_reg;
    logic [CHUNK_WIDTH-1:0] z_slices_reg [CHUNK_COUNT];

    logic [CHUNK_WIDTH-1:0] x_slices [CHUNK_COUNT];
    logic [CHUNK_WIDTH-1:0] y_slices [CHUNK_COUNT];
    logic [CHUNK_WIDTH-1:0] slice_a, slice_b, slice_sum;
    logic                   slice_carry;
    logic                   accept;
    logic                   running;
    logic                   last_slice;

    // A new operation is only taken when no slices are in flight.
    assign accept     = start && (state_reg != RUN);
    assign running    = (state_reg == RUN);
    assign last_slice = (idx_reg == LAST_IDX);

    generate
        for (genvar gi = 0; gi < CHUNK_COUNT; gi++) begin : g_split
            assign x_slices[gi] = x_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
            assign y_slices[gi] = y_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
        end
    endgenerate

    assign slice_a = x_slices[idx_reg];
    assign slice_b = y_slices[idx_reg];

    group_ripple_carry_adder #(
        .WIDTH(CHUNK_WIDTH)
    ) u_slice_adder (
        .a        (slice_a),
        .b        (slice_b),
        .carry_in (carry_reg),
        .sum      (slice_sum),
        .carry_out(slice_carry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_reg       <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
        end else if (accept) begin
            idx_reg   <= '0;
            x_reg     <= x;
            y_reg     <= y;
            carry_reg <= carry_in;
        end else if (running) begin
            carry_reg <= slice_carry;
            if (last_slice) begin
                carry_out_reg <= slice_carry;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Each result slice has its own register so it only changes on its own RUN cycle.
    generate
        for (genvar gi = 0; gi < CHUNK_COUNT; gi++) begin : g_result
            always_ff @(posedge clock) begin
                if (reset) begin
                    z_slices_reg[gi] <= '0;
                end else if (running && (idx_reg == IDX_W'(gi))) begin
                    z_slices_reg[gi] <= slice_sum;
                end
            end
            assign z[gi*CHUNK_WIDTH +: CHUNK_WIDTH] = z_slices_reg[gi];
        end
    endgenerate

    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign carry_out = carry_out_reg;

endmodule
